// File: rtl/mem_arbiter.sv
// mem_arbiter: lets two cache controllers share one external memory channel.
//   Client 0 (I-cache refill) issues reads only. Client 1 (D-cache) issues
//   reads and writes; a write request is followed by a DATA_CYCLES-beat burst.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   c0_req_*               client 0 read request (valid/ready/addr/tag)
//   c1_req_*               client 1 request (valid/ready/rw/addr/tag)
//   c1_data_*              client 1 write beats (valid/ready/bits/mask)
//   c0/c1_resp_valid       per-client response beat strobe
//   resp_tag, resp_data    shared response tag (client id stripped) and data
//   mem_req_*              request channel to memory, tag = {client id, tag}
//   mem_req_data_*         write-data channel to memory
//   mem_resp_*             response channel from memory (no backpressure)
module mem_arbiter #(
  parameter int ADDR_BITS       = 28,
  parameter int TAG_BITS        = 5,
  parameter int DATA_BITS       = 128,
  parameter int DATA_CYCLES     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_valid,
  output logic                   c0_req_ready,
  input  logic [ADDR_BITS-1:0]   c0_req_addr,
  input  logic [TAG_BITS-2:0]    c0_req_tag,
  output logic                   c0_resp_valid,
  input  logic                   c1_req_valid,
  output logic                   c1_req_ready,
  input  logic                   c1_req_rw,
  input  logic [ADDR_BITS-1:0]   c1_req_addr,
  input  logic [TAG_BITS-2:0]    c1_req_tag,
  input  logic                   c1_data_valid,
  output logic                   c1_data_ready,
  input  logic [DATA_BITS-1:0]   c1_data_bits,
  input  logic [DATA_BITS/8-1:0] c1_data_mask,
  output logic                   c1_resp_valid,
  output logic [TAG_BITS-2:0]    resp_tag,
  output logic [DATA_BITS-1:0]   resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int BW = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(DATA_CYCLES - 1);
  localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;

  state_t                r_state, w_next;
  logic                  r_rw;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [TAG_BITS-1:0]   r_tag;
  logic                  r_last_grant;
  logic [BW-1:0]         r_wbeat, r_rbeat0, r_rbeat1;
  logic [OW-1:0]         r_out0, r_out1;

  logic w_idle, w_elig0, w_elig1, w_gnt0, w_gnt1;
  logic w_req_hs, w_data_hs, w_wlast;
  logic w_rsp0, w_rsp1, w_last0, w_last1;
  logic w_inc0, w_inc1, w_dec0, w_dec1;

  // Writes are never throttled; only reads count against the in-flight limit.
  assign w_idle  = (r_state == IDLE) && !reset;
  assign w_elig0 = c0_req_valid && (r_out0 < MAX_OUT);
  assign w_elig1 = c1_req_valid && (c1_req_rw || (r_out1 < MAX_OUT));
  // On a tie the client that did not win last time goes first.
  assign w_gnt0  = w_idle && w_elig0 && (!w_elig1 || r_last_grant);
  assign w_gnt1  = w_idle && w_elig1 && !w_gnt0;

  assign w_req_hs  = (r_state == REQ) && mem_req_ready;
  assign w_data_hs = (r_state == WDATA) && c1_data_valid && mem_req_data_ready;
  assign w_wlast   = w_data_hs && (r_wbeat == LAST_BEAT);

  assign w_rsp0  = !reset && mem_resp_valid && !mem_resp_tag[TAG_BITS-1];
  assign w_rsp1  = !reset && mem_resp_valid &&  mem_resp_tag[TAG_BITS-1];
  assign w_last0 = w_rsp0 && (r_rbeat0 == LAST_BEAT);
  assign w_last1 = w_rsp1 && (r_rbeat1 == LAST_BEAT);

  assign w_inc0 = w_req_hs && !r_rw && !r_tag[TAG_BITS-1];
  assign w_inc1 = w_req_hs && !r_rw &&  r_tag[TAG_BITS-1];
  // A stray response with nothing outstanding is forwarded but not counted.
  assign w_dec0 = w_last0 && (r_out0 != '0);
  assign w_dec1 = w_last1 && (r_out1 != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt0 || w_gnt1) w_next = REQ;
      REQ:     if (mem_req_ready) w_next = r_rw ? WDATA : IDLE;
      WDATA:   if (w_wlast) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    c0_req_ready       = w_gnt0;
    c1_req_ready       = w_gnt1;
    mem_req_valid      = (r_state == REQ);
    mem_req_rw         = r_rw;
    mem_req_addr       = r_addr;
    mem_req_tag        = r_tag;
    mem_req_data_valid = 1'b0;
    c1_data_ready      = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    if (r_state == WDATA) begin
      mem_req_data_valid = c1_data_valid;
      c1_data_ready      = mem_req_data_ready;
      mem_req_data_bits  = c1_data_bits;
      mem_req_data_mask  = c1_data_mask;
    end
    c0_resp_valid = w_rsp0;
    c1_resp_valid = w_rsp1;
    resp_tag      = reset ? '0 : mem_resp_tag[TAG_BITS-2:0];
    resp_data     = reset ? '0 : mem_resp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_tag        <= '0;
      r_last_grant <= 1'b1;
      r_wbeat      <= '0;
      r_rbeat0     <= '0;
      r_rbeat1     <= '0;
      r_out0       <= '0;
      r_out1       <= '0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_rw         <= w_gnt1 && c1_req_rw;
        r_addr       <= w_gnt1 ? c1_req_addr : c0_req_addr;
        r_tag        <= {w_gnt1, (w_gnt1 ? c1_req_tag : c0_req_tag)};
        r_last_grant <= w_gnt1;
      end
      if (w_data_hs) r_wbeat  <= w_wlast ? '0 : r_wbeat + BW'(1);
      if (w_rsp0)    r_rbeat0 <= w_last0 ? '0 : r_rbeat0 + BW'(1);
      if (w_rsp1)    r_rbeat1 <= w_last1 ? '0 : r_rbeat1 + BW'(1);
      case ({w_inc0, w_dec0})
        2'b10:   r_out0 <= r_out0 + OW'(1);
        2'b01:   r_out0 <= r_out0 - OW'(1);
        default: r_out0 <= r_out0;
      endcase
      case ({w_inc1, w_dec1})
        2'b10:   r_out1 <= r_out1 + OW'(1);
        2'b01:   r_out1 <= r_out1 - OW'(1);
        default: r_out1 <= r_out1;
      endcase
    end
  end
endmodule
